// File: rtl/alu_ex_stage_if.sv
// ============================================================================
//  Module   : alu_ex_stage_if
//  Purpose  : Operand/control bundle between ALU control, EX stage and MEM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_ex_stage_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       aluctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_in;
    logic             stall_in;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             valid_out;
    logic             busy;

    modport master (
        output aluctl, a, b, valid_in, stall_in, flush,
        input  result, zero, overflow, valid_out, busy
    );

    modport slave (
        input  aluctl, a, b, valid_in, stall_in, flush,
        output result, zero, overflow, valid_out, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_ex_stage.sv
// ============================================================================
//  Module   : alu_ex_stage
//  Purpose  : Pipelined ALU execute stage with registered EX/MEM outputs.
//             Define ALU_EX_MULT_EN to add an iterative multiplier on op 4'h3.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_ex_stage_if.slave ex_if
);

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_NOR = 4'hc;
    localparam logic [3:0] OP_XOR = 4'hd;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic             w_busy;
    logic             w_accept;

    // Single adder serves ADD and SUB; SUB feeds the two's complement of b.
    always_comb begin
        w_b_eff   = (ex_if.aluctl == OP_SUB) ? (~ex_if.b + WIDTH'(1)) : ex_if.b;
        w_sum     = ex_if.a + w_b_eff;
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (ex_if.aluctl)
            OP_AND: w_alu_res = ex_if.a & ex_if.b;
            OP_OR:  w_alu_res = ex_if.a | ex_if.b;
            OP_ADD, OP_SUB: begin
                w_alu_res = w_sum;
                w_alu_ovf = (ex_if.a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != ex_if.a[WIDTH-1]);
            end
            OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}},
                                 ($signed(ex_if.a) < $signed(ex_if.b))};
            OP_NOR: w_alu_res = ~(ex_if.a | ex_if.b);
            OP_XOR: w_alu_res = ex_if.a ^ ex_if.b;
            default: begin
                w_alu_res = '0;
                w_alu_ovf = 1'b0;
            end
        endcase
    end

`ifdef ALU_EX_MULT_EN
    localparam logic [3:0] OP_MUL = 4'h3;
    localparam int         CW     = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] w_acc_step;

    assign w_acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign w_busy     = (state_q == ST_MUL);
`else
    assign w_busy     = 1'b0;
`endif

    assign w_accept = ex_if.valid_in & ~w_busy & ~ex_if.stall_in & ~ex_if.flush;

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
`ifdef ALU_EX_MULT_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`endif
        if (ex_if.flush) begin
            valid_d = 1'b0;
`ifdef ALU_EX_MULT_EN
            state_d = ST_IDLE;
`endif
        end else if (ex_if.stall_in) begin
            valid_d = valid_q;
`ifdef ALU_EX_MULT_EN
        end else if (state_q == ST_MUL) begin
            acc_d    = w_acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                result_d = w_acc_step;
                zero_d   = (w_acc_step == '0);
                ovf_d    = 1'b0;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
        end else if (w_accept && (ex_if.aluctl == OP_MUL)) begin
            state_d  = ST_MUL;
            cnt_d    = CW'(WIDTH);
            mcand_d  = ex_if.a;
            mplier_d = ex_if.b;
            acc_d    = '0;
            valid_d  = 1'b0;
`endif
        end else if (w_accept) begin
            result_d = w_alu_res;
            zero_d   = (w_alu_res == '0);
            ovf_d    = w_alu_ovf;
            valid_d  = 1'b1;
        end else begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

`ifdef ALU_EX_MULT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
`endif

    assign ex_if.result    = result_q;
    assign ex_if.zero      = zero_q;
    assign ex_if.overflow  = ovf_q;
    assign ex_if.valid_out = valid_q;
    assign ex_if.busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
// ============================================================================
//  Module   : tb_alu_ex_stage
//  Purpose  : Directed, scoreboard-based bench for alu_ex_stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_ex_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ex_stage_if #(.WIDTH(W)) bus ();

    alu_ex_stage #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .ex_if (bus)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.res = '0;
        e.ovf = 1'b0;
        case (ctl)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h2: begin
                e.res = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'h6: begin
                e.res = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'h7: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
            4'hc: e.res = ~(a | b);
            4'hd: e.res = a ^ b;
`ifdef ALU_EX_MULT_EN
            4'h3: e.res = a * b;
`endif
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=output expected=empty_scoreboard", tag);
        end else begin
            e    = sb_q.pop_front();
            last = e;
            check({tag, ".result"},   bus.result,   e.res);
            check({tag, ".zero"},     bus.zero,     e.z);
            check({tag, ".overflow"}, bus.overflow, e.ovf);
        end
    endtask

    task automatic single_op(input string tag, input logic [3:0] ctl,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        bus.aluctl   = ctl;
        bus.a        = a;
        bus.b        = b;
        bus.valid_in = 1'b1;
        sb_q.push_back(model(ctl, a, b));
        tick();
        bus.valid_in = 1'b0;
        check({tag, ".valid_out"}, bus.valid_out, 1);
        check({tag, ".busy"},      bus.busy,      0);
        pop_cmp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] op_tab [7] = '{4'h0, 4'h1, 4'hc, 4'hd, 4'h7, 4'h5, 4'hf};

    initial begin
        bus.aluctl   = 4'h0;
        bus.a        = '0;
        bus.b        = '0;
        bus.valid_in = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst.result",    bus.result,    0);
        check("rst.zero",      bus.zero,      1);
        check("rst.overflow",  bus.overflow,  0);
        check("rst.valid_out", bus.valid_out, 0);
        check("rst.busy",      bus.busy,      0);

        single_op("add_ovf", 4'h2, 32'h7fffffff, 32'h1);
        check("add_ovf.exp_result", bus.result, 32'h80000000);
        tick();
        check("add_ovf.next_valid", bus.valid_out, 0);
        check("add_ovf.hold",       bus.result,    32'h80000000);

        single_op("sub_eq", 4'h6, 32'd5, 32'd5);
        bus.stall_in = 1'b1;
        bus.valid_in = 1'b1;
        bus.aluctl   = 4'h2;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.valid_out", bus.valid_out, 1);
            check("stall.result",    bus.result,    0);
            check("stall.zero",      bus.zero,      1);
        end
        bus.stall_in = 1'b0;
        bus.valid_in = 1'b0;
        tick();
        check("stall_rel.valid_out", bus.valid_out, 0);
        check("stall_rel.result",    bus.result,    0);

        single_op("slt_neg", 4'h7, 32'hffffffff, 32'h0);
        check("slt_neg.one", bus.result, 1);
        single_op("sub_ovf", 4'h6, 32'h80000000, 32'h1);
        single_op("add_wrap", 4'h2, 32'hffffffff, 32'h1);

        for (int i = 0; i < 7; i++)
            single_op("op_tab", op_tab[i], $urandom, $urandom);

        single_op("pre_flush", 4'h2, 32'd10, 32'd20);
        bus.valid_in = 1'b1;
        bus.aluctl   = 4'hd;
        bus.a        = 32'h1234;
        bus.b        = 32'h4321;
        bus.flush    = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        check("flush.valid_out", bus.valid_out, 0);
        check("flush.result",    bus.result,    last.res);

`ifndef ALU_EX_MULT_EN
        single_op("op3_unknown", 4'h3, 32'd3, 32'd4);
        check("op3_unknown.zero1", bus.zero, 1);
`else
        bus.aluctl   = 4'h3;
        bus.a        = 32'd1234;
        bus.b        = 32'd5678;
        bus.valid_in = 1'b1;
        sb_q.push_back(model(4'h3, 32'd1234, 32'd5678));
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("mul.busy",  bus.busy,      1);
            check("mul.valid", bus.valid_out, 0);
            tick();
        end
        check("mul.done_valid", bus.valid_out, 1);
        check("mul.done_busy",  bus.busy,      0);
        pop_cmp("mul");
        check("mul.exp_result", bus.result, 32'd7006652);

        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mulflush.busy_before", bus.busy, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("mulflush.busy",  bus.busy,      0);
        check("mulflush.valid", bus.valid_out, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("mulflush.no_valid", bus.valid_out, 0);
        end
`endif

        bus.valid_in = 1'b1;
        bus.aluctl   = 4'h2;
        bus.a        = 32'd3;
        bus.b        = 32'd4;
        rst          = 1'b1;
        tick();
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        check("rst_prio.result",    bus.result,    0);
        check("rst_prio.zero",      bus.zero,      1);
        check("rst_prio.valid_out", bus.valid_out, 0);
        check("rst_prio.busy",      bus.busy,      0);
        check("sb.empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 aluctl  input  4  operation code from ALU control stage.
REQ-005 a  input  WIDTH  operand A (rs value).
REQ-006 b  input  WIDTH  operand B (rt value or sign-extended immediate).
REQ-007 valid_in  input  1  operands and aluctl valid this cycle.
REQ-008 stall_in  input  1  downstream (MEM) stall; hold EX/MEM outputs.
REQ-009 flush  input  1  squash current and in-flight operation.
REQ-010 result  output  WIDTH  registered ALU result (EX/MEM register).
REQ-011 zero  output  1  registered, high when result is all zeros.
REQ-012 overflow  output  1  registered signed overflow for add/sub.
REQ-013 valid_out  output  1  result/zero/overflow valid.
REQ-014 busy  output  1  stage occupied; upstream SHALL hold inputs while high.

Function
REQ-015 Opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB (a-b), 7 SLT (signed, result 1 or 0), 4'hc NOR, 4'hd XOR; all others give result 0, overflow 0.
REQ-016 Accept condition: valid_in & !busy & !stall_in & !flush.
REQ-017 Single-cycle ops: latency 1; on accept, result/zero/overflow load and valid_out=1 the next cycle.
REQ-018 No accept and no stall_in: valid_out=0 next cycle; result/zero/overflow hold last values.
REQ-019 stall_in high: result, zero, overflow, valid_out hold unchanged; valid_in ignored.
REQ-020 Arithmetic modulo 2^WIDTH; overflow = sign(a)==sign(b') & sign(sum)!=sign(a), b'=b for ADD, ~b+1 for SUB; overflow 0 for non-arith ops.
REQ-021 zero computed from the value being loaded into result, registered together with it.
REQ-022 flush: valid_out=0 next cycle, any multi-cycle op aborted, busy=0 next cycle; flush beats stall_in and valid_in.
REQ-023 Unknown aluctl with valid accept: valid_out=1, result 0, zero 1.

Reset
REQ-024 rst SHALL be sampled on rising clk only; rst has priority over flush, stall_in, valid_in.
REQ-025 After reset: result 0, zero 1, overflow 0, valid_out 0, busy 0, state IDLE, multiplier counters 0.
REQ-026 rst asserted mid-multiply SHALL abort it; no valid_out pulse for the aborted op.

Configuration
REQ-027 Macro ALU_EX_MULT_EN compiles in an iterative unsigned multiplier on aluctl 4'h3.
REQ-028 With macro: FSM states IDLE, MUL; accept of 4'h3 in IDLE -> MUL, busy=1 next cycle, counter loaded WIDTH.
REQ-029 MUL: one shift-add step per cycle not stalled by stall_in; after WIDTH steps result = low WIDTH bits of a*b, zero updated, overflow 0, valid_out=1, busy=0, -> IDLE.
REQ-030 Latency accept-to-valid_out = WIDTH+1 cycles plus stall cycles; stall_in in MUL freezes counter and partial product.
REQ-031 valid_in while busy is ignored; flush/rst in MUL -> IDLE (REQ-022, REQ-026).
REQ-032 Without macro: 4'h3 is an unknown opcode (REQ-023), busy tied 0, no FSM logic present.

Verification
REQ-033 After reset, no valid_in -> result 0, zero 1, overflow 0, valid_out 0, busy 0.
REQ-034 aluctl 2, a=32'h7fffffff, b=1, valid_in 1 cycle -> next cycle result 32'h80000000, overflow 1, zero 0, valid_out 1; following cycle valid_out 0.
REQ-035 aluctl 6, a=5, b=5 accepted, stall_in high 3 cycles next -> result 0, zero 1, valid_out 1 held all 3 cycles; aluctl 7, a=-1, b=0 -> result 1.
REQ-036 Accept op, flush same cycle as next valid_in -> valid_out 0 next cycle, result unchanged.
REQ-037 ALU_EX_MULT_EN defined, aluctl 3, a=1234, b=5678 -> busy high 32 cycles, valid_out 1 on cycle 33 with result 7006652; repeat with flush at cycle 10 -> busy 0 next cycle, no valid_out.
REQ-038 ALU_EX_MULT_EN undefined, aluctl 3, a=3, b=4 -> next cycle result 0, zero 1, valid_out 1, busy never high.
